regfile_write_bank_16x32: RTL and testbench



---
 rtl/regfile_write_bank_16x32.sv | 101 ++++++++++
 tb/tb_regfile_write_bank_16x32.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/regfile_write_bank_16x32.sv
// rtl/regfile_write_bank_16x32.sv - write side of the 16x32 register file with byte merge and dirty bitmap
module regfile_write_bank_16x32 #(
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        WE,
    input  logic [3:0]  WA,
    input  logic [31:0] D,
    input  logic [3:0]  BE,
    input  logic        ClrDirty,
    output logic [31:0] O0,
    output logic [31:0] O1,
    output logic [31:0] O2,
    output logic [31:0] O3,
    output logic [31:0] O4,
    output logic [31:0] O5,
    output logic [31:0] O6,
    output logic [31:0] O7,
    output logic [31:0] O8,
    output logic [31:0] O9,
    output logic [31:0] O10,
    output logic [31:0] O11,
    output logic [31:0] O12,
    output logic [31:0] O13,
    output logic [31:0] O14,
    output logic [31:0] O15,
    output logic [15:0] Dirty
);

    logic [31:0] regs_q [16];
    logic [15:0] wr_en;
    logic [15:0] dirty_q;
    logic [15:0] dirty_d;

    for (genvar i = 0; i < 16; i++) begin : g_reg
        if (ZERO_R0 && (i == 0)) begin : g_zero
            // Hardwired zero: no storage and never reported dirty.
            assign wr_en[i]  = 1'b0;
            assign regs_q[i] = 32'h0;
        end else begin : g_store
            logic [31:0] r_q;
            logic [31:0] r_d;

            assign wr_en[i] = WE && (WA == 4'(i)) && (BE != 4'b0000);

            always_comb begin
                r_d = r_q;
                for (int k = 0; k < 4; k++) begin
                    if (BE[k]) begin
                        r_d[8*k +: 8] = D[8*k +: 8];
                    end
                end
            end

            always_ff @(posedge Clk) begin
                if (!Clr) begin
                    r_q <= 32'h0;
                end else if (wr_en[i]) begin
                    r_q <= r_d;
                end
            end

            assign regs_q[i] = r_q;
        end
    end

    // A write in the same cycle as a clear wins for its own bit.
    always_comb begin
        dirty_d = ClrDirty ? 16'h0000 : dirty_q;
        dirty_d = dirty_d | wr_en;
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            dirty_q <= 16'h0000;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign Dirty = dirty_q;

    assign O0  = regs_q[0];
    assign O1  = regs_q[1];
    assign O2  = regs_q[2];
    assign O3  = regs_q[3];
    assign O4  = regs_q[4];
    assign O5  = regs_q[5];
    assign O6  = regs_q[6];
    assign O7  = regs_q[7];
    assign O8  = regs_q[8];
    assign O9  = regs_q[9];
    assign O10 = regs_q[10];
    assign O11 = regs_q[11];
    assign O12 = regs_q[12];
    assign O13 = regs_q[13];
    assign O14 = regs_q[14];
    assign O15 = regs_q[15];

endmodule

// File: tb/tb_regfile_write_bank_16x32.sv
// tb/tb_regfile_write_bank_16x32.sv - randomized self-checking bench for both ZERO_R0 settings
module tb_regfile_write_bank_16x32;

    logic        Clk = 1'b0;
    logic        Clr, WE, ClrDirty;
    logic [3:0]  WA, BE;
    logic [31:0] D;

    logic [31:0] oz [16];
    logic [31:0] on [16];
    logic [15:0] dirty_z, dirty_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_z [16];
    logic [31:0] m_n [16];
    logic [15:0] md_z, md_n;

    always #5 Clk = ~Clk;

    regfile_write_bank_16x32 #(.ZERO_R0(1'b1)) u_dut_z (
        .Clk(Clk), .Clr(Clr), .WE(WE), .WA(WA), .D(D), .BE(BE), .ClrDirty(ClrDirty),
        .O0(oz[0]), .O1(oz[1]), .O2(oz[2]), .O3(oz[3]), .O4(oz[4]), .O5(oz[5]),
        .O6(oz[6]), .O7(oz[7]), .O8(oz[8]), .O9(oz[9]), .O10(oz[10]), .O11(oz[11]),
        .O12(oz[12]), .O13(oz[13]), .O14(oz[14]), .O15(oz[15]), .Dirty(dirty_z)
    );

    regfile_write_bank_16x32 #(.ZERO_R0(1'b0)) u_dut_n (
        .Clk(Clk), .Clr(Clr), .WE(WE), .WA(WA), .D(D), .BE(BE), .ClrDirty(ClrDirty),
        .O0(on[0]), .O1(on[1]), .O2(on[2]), .O3(on[3]), .O4(on[4]), .O5(on[5]),
        .O6(on[6]), .O7(on[7]), .O8(on[8]), .O9(on[9]), .O10(on[10]), .O11(on[11]),
        .O12(on[12]), .O13(on[13]), .O14(on[14]), .O15(on[15]), .Dirty(dirty_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s z O%0d", phase, i), oz[i], m_z[i]);
            chk($sformatf("%s n O%0d", phase, i), on[i], m_n[i]);
        end
        chk({phase, " z Dirty"}, {16'h0, dirty_z}, {16'h0, md_z});
        chk({phase, " n Dirty"}, {16'h0, dirty_n}, {16'h0, md_n});
    endtask

    // Reference: a register file is an array of words; a write replaces the enabled bytes.
    task automatic model_edge(input logic clr, input logic we, input logic [3:0] wa,
                              input logic [31:0] d, input logic [3:0] be, input logic clrd);
        if (!clr) begin
            for (int i = 0; i < 16; i++) begin
                m_z[i] = 0;
                m_n[i] = 0;
            end
            md_z = 0;
            md_n = 0;
        end else begin
            if (clrd) begin
                md_z = 0;
                md_n = 0;
            end
            if (we && be != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        m_n[wa][8*k +: 8] = d[8*k +: 8];
                        if (wa != 0) m_z[wa][8*k +: 8] = d[8*k +: 8];
                    end
                end
                md_n[wa] = 1'b1;
                if (wa != 0) md_z[wa] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic clr, input logic we, input logic [3:0] wa,
                       input logic [31:0] d, input logic [3:0] be, input logic clrd);
        Clr = clr; WE = we; WA = wa; D = d; BE = be; ClrDirty = clrd;
        #2;
        check_all("pre");
        @(posedge Clk);
        model_edge(clr, we, wa, d, be, clrd);
        #1;
        check_all("post");
    endtask

    initial begin
        Clr = 1'b0; WE = 1'b0; WA = 0; D = 0; BE = 0; ClrDirty = 1'b0;
        @(posedge Clk);
        model_edge(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        #1;
        check_all("reset");

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'(i), $urandom, 4'hF, 1'b0);
        cyc(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'hF, 1'b0);
        chk("rst O5", on[5], 32'h0);
        chk("rst Dirty", {16'h0, dirty_n}, 32'h0);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'(i), 32'hA5A5_0000 + i, 4'hF, 1'b0);
        chk("sweep z O0", oz[0], 32'h0);
        chk("sweep n O0", on[0], 32'hA5A5_0000);
        chk("sweep z O15", oz[15], 32'hA5A5_000F);
        chk("sweep z Dirty", {16'h0, dirty_z}, 32'h0000_FFFE);
        chk("sweep n Dirty", {16'h0, dirty_n}, 32'h0000_FFFF);

        cyc(1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'hF, 1'b0);
        cyc(1'b1, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 1'b0);
        chk("merge O3", oz[3], 32'h11BB_33DD);
        cyc(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        chk("be0 O3", oz[3], 32'h11BB_33DD);

        cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        chk("lat O7 before", oz[7], 32'h0);
        cyc(1'b1, 1'b1, 4'd7, 32'd1, 4'hF, 1'b0);
        chk("lat O7 N", oz[7], 32'd1);
        cyc(1'b1, 1'b1, 4'd7, 32'd2, 4'hF, 1'b0);
        chk("lat O7 N+1", oz[7], 32'd2);

        cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        for (int i = 4; i < 8; i++) cyc(1'b1, 1'b1, 4'(i), $urandom, 4'hF, 1'b0);
        chk("coll pre Dirty", {16'h0, dirty_z}, 32'h0000_00F0);
        cyc(1'b1, 1'b1, 4'd9, $urandom, 4'hF, 1'b1);
        chk("coll Dirty", {16'h0, dirty_z}, 32'h0000_0200);

        for (int c = 0; c < 100; c++)
            cyc(1'b1, 1'b0, 4'($urandom), $urandom, 4'($urandom), 1'b0);

        for (int c = 0; c < 300; c++)
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0), 4'($urandom),
                $urandom, 4'($urandom), ($urandom_range(0, 15) == 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
